// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style memory port among NUM_CORES cores,
// with per-transaction ownership and an optional timeout that returns an error pulse.
module mem_bus_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CORES-1:0]              core_cyc,
  input  logic [NUM_CORES-1:0]              core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]   core_adr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   core_dat,
  input  logic [NUM_CORES*DATA_WIDTH/8-1:0] core_sel,
  output logic [NUM_CORES-1:0]              core_ack,
  output logic [NUM_CORES-1:0]              core_err,
  output logic [DATA_WIDTH-1:0]             core_rdt,
  output logic                              mem_cyc,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_adr,
  output logic [DATA_WIDTH-1:0]             mem_dat,
  output logic [DATA_WIDTH/8-1:0]           mem_sel,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_rdt,
  output logic [NUM_CORES-1:0]              grant
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_CORES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, next_state;
  logic [IW-1:0] last, owner, pick;
  logic          any_req;
  logic [CW-1:0] cnt;
  logic          timeout;
  int unsigned   scan_idx;

  // Scan requesters starting at the core after the last one served, wrapping around.
  always_comb begin
    pick     = '0;
    any_req  = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      scan_idx = (int'(last) + k) % NUM_CORES;
      if (!any_req && ((core_cyc & (NUM_CORES'(1) << scan_idx)) != '0)) begin
        any_req = 1'b1;
        pick    = IW'(scan_idx);
      end
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = BUSY;
      BUSY:    if (mem_ack || timeout) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      owner    <= '0;
      last     <= IDX_MAX;
      cnt      <= '0;
      core_ack <= '0;
      core_err <= '0;
      core_rdt <= '0;
      mem_cyc  <= 1'b0;
      mem_we   <= 1'b0;
      mem_adr  <= '0;
      mem_dat  <= '0;
      mem_sel  <= '0;
    end else begin
      core_ack <= '0;
      core_err <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= pick;
            grant   <= NUM_CORES'(1) << pick;
            mem_cyc <= 1'b1;
            mem_we  <= core_we[pick];
            mem_adr <= core_adr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            mem_dat <= core_dat[pick*DATA_WIDTH +: DATA_WIDTH];
            mem_sel <= core_sel[pick*SEL_WIDTH +: SEL_WIDTH];
            cnt     <= '0;
          end
        end
        BUSY: begin
          // Ack takes precedence over a timeout firing in the same cycle.
          if (mem_ack) begin
            core_rdt <= mem_rdt;
            core_ack <= grant;
            mem_cyc  <= 1'b0;
            last     <= owner;
          end else if (timeout) begin
            core_err <= grant;
            mem_cyc  <= 1'b0;
            last     <= owner;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: grant <= '0;
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one Wishbone-style memory port among NUM_CORES SERV cores in the serv-gpu array. Each granted core owns the port for a full transaction, from request through acknowledge. Fairness is round-robin, starting from the core after the one last served. A per-transaction timeout returns an error pulse, so a silent memory cannot hang a core.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (≥1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for mem_ack; 0 disables the timeout

Ports (core i uses slice [i*W +: W] of each flattened bus):
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- core_cyc  in  NUM_CORES  per-core request; held until that core's ack/err
- core_we  in  NUM_CORES  per-core write enable
- core_adr  in  NUM_CORES*ADDR_WIDTH  per-core address
- core_dat  in  NUM_CORES*DATA_WIDTH  per-core write data
- core_sel  in  NUM_CORES*SEL_WIDTH  per-core byte select
- core_ack  out  NUM_CORES  one-cycle completion pulse, one-hot
- core_err  out  NUM_CORES  one-cycle timeout pulse, one-hot
- core_rdt  out  DATA_WIDTH  registered read data, broadcast to all cores
- mem_cyc  out  1  memory request
- mem_we, mem_adr, mem_dat, mem_sel  out  1/ADDR_WIDTH/DATA_WIDTH/SEL_WIDTH  latched from the granted core
- mem_ack  in  1  memory completion
- mem_rdt  in  DATA_WIDTH  memory read data, valid with mem_ack
- grant  out  NUM_CORES  one-hot owner; zero when idle

## Operation
- FSM has three states:
  - IDLE: no transaction in flight.
  - BUSY: mem_cyc=1; waiting on memory.
  - RESP: ack or err driven to the owning core.
- Reset values:
  - state=IDLE; grant, core_ack, core_err, mem_cyc, mem_we = 0; mem_adr, mem_dat, mem_sel, core_rdt = 0.
  - last = NUM_CORES-1, so core 0 has first priority.
- IDLE with any core_cyc set:
  - Select the first requester scanning (last+1), (last+2), … mod NUM_CORES, with wrap-around.
  - Register its one-hot grant and latch its we/adr/dat/sel onto mem_*.
  - Set mem_cyc=1, clear the timeout counter, go to BUSY.
- IDLE with no request: all outputs stay idle.
- BUSY with mem_ack=1:
  - core_rdt <= mem_rdt; core_ack[g] <= 1; mem_cyc <= 0; last <= g; go to RESP.
  - core_rdt is updated for writes as well.
- BUSY, no ack, counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0):
  - core_err[g] <= 1; mem_cyc <= 0; last <= g; go to RESP.
  - core_rdt is unchanged.
- BUSY otherwise: counter increments and mem_* is held stable.
- RESP:
  - ack/err is high for exactly this cycle; grant stays on the owner.
  - Next cycle: ack/err=0, grant=0, state=IDLE.
  - core_cyc is not sampled in RESP, so the owner's same-cycle drop is never double-served.
- core_cyc dropped mid-BUSY is a protocol violation. It is ignored: the transaction completes and ack/err still pulses.
- mem_ack in the same cycle the timeout would fire: ack wins and no err is issued.
- mem_ack outside BUSY is ignored.
- NUM_CORES=1 uses the same FSM; the scan degenerates to core 0.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter never wraps.
- Reset asserted in any state:
  - Next cycle is the full reset state; any in-flight transaction is abandoned with no ack/err.
  - mem_cyc drops one cycle after rst is sampled.

## Timing
- Request visible in IDLE at cycle 0 -> grant and mem_cyc high from cycle 1.
- mem_ack sampled in cycle k≥1 -> core_ack in cycle k+1 -> IDLE in cycle k+2, re-arbitration there.
- Zero-wait memory (ack in cycle 1) gives 3 cycles per transaction and core_ack in cycle 2.
- Timeout fires at cycle TIMEOUT_CYCLES with no ack -> core_err in cycle TIMEOUT_CYCLES+1.
- All outputs are registered; there is no combinational path from core_* or mem_ack to any output.

## Test plan
- **Reset defaults:** after reset, all outputs are zero. core_cyc=4'b1111 with zero-wait memory grants in order 0,1,2,3,0; each core_ack comes 3 cycles after the previous one.
- **Single core, wait states:** core_cyc=4'b0100, read adr 0x100, mem_ack after 5 BUSY cycles, mem_rdt=0xDEADBEEF. Required: grant=4'b0100; mem_adr=0x100; core_ack=4'b0100 one cycle after mem_ack; core_rdt=0xDEADBEEF.
- **Write passthrough and fairness:** core 3 writes dat=0x12345678, sel=4'b0011. Required: mem_we=1 with those values held through BUSY. A following core_cyc=4'b1001 is served core 0 first, since last=3.
- **Timeout:** TIMEOUT_CYCLES=4, core 1 requests, mem_ack never asserted. Required: mem_cyc high for 4 cycles, then core_err=4'b0010 for one cycle, core_ack=0, core_rdt unchanged. The next request is served normally.
- **Ack vs timeout collision:** mem_ack on the final timeout cycle. Required: core_ack pulses and core_err stays 0.
- **Reset mid-BUSY:** rst asserted on the 2nd BUSY cycle. Required: next cycle mem_cyc=0, grant=0, no ack/err; the first post-reset grant goes to the lowest-indexed requester.
